// File: rtl/led_cube_pkg.sv
// Shared definitions for the LED cube sequencer: state encoding used on state_dbg
// and the default game size. The datapath bench decodes state_dbg with these codes.
package led_cube_pkg;

    localparam logic [2:0] ST_OFF      = 3'd0;
    localparam logic [2:0] ST_CDOWN    = 3'd1;
    localparam logic [2:0] ST_WAIT_POS = 3'd2;
    localparam logic [2:0] ST_LD_POS   = 3'd3;
    localparam logic [2:0] ST_WAIT_COL = 3'd4;
    localparam logic [2:0] ST_LD_COL   = 3'd5;
    localparam logic [2:0] ST_CHECK    = 3'd6;
    localparam logic [2:0] ST_ANIM     = 3'd7;

    typedef enum logic [2:0] {
        S_OFF      = ST_OFF,
        S_CDOWN    = ST_CDOWN,
        S_WAIT_POS = ST_WAIT_POS,
        S_LD_POS   = ST_LD_POS,
        S_WAIT_COL = ST_WAIT_COL,
        S_LD_COL   = ST_LD_COL,
        S_CHECK    = ST_CHECK,
        S_ANIM     = ST_ANIM
    } state_t;

    localparam int unsigned MAX_MOVES_DEF = 16;
    localparam int unsigned MOVE_W_DEF    = 5;

    function automatic logic [3:0] state_code(input state_t s);
        return {1'b0, s};
    endfunction

endpackage

// File: rtl/led_ctrl_timer.sv
// Up-counter with clear, load and enable; tc pulses on the enabled cycle where the
// count sits at TERM-1, and the count then wraps to zero.
module led_ctrl_timer #(
    parameter int unsigned TERM = 8,
    parameter int unsigned W    = (TERM > 1) ? $clog2(TERM) : 1
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         en,
    input  logic         clr,
    input  logic         ld,
    input  logic [W-1:0] ld_val,
    output logic         tc
);

    localparam logic [W-1:0] LAST = W'(TERM - 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign tc = en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (ld)
            cnt_d = ld_val;
        else if (en)
            cnt_d = tc ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!resetn)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/led_cube_ctrl.sv
// Game sequencer for the LED cube: countdown, placements, end animation, idle timeout.
// Optional pause support is built when LED_CTRL_PAUSE_EN is defined.
module led_cube_ctrl
    import led_cube_pkg::*;
#(
    parameter int unsigned MAX_MOVES    = MAX_MOVES_DEF,
    parameter int unsigned MOVE_W       = MOVE_W_DEF,
    parameter int unsigned IDLE_TIMEOUT = 500000000,
    parameter int unsigned ANIM_CYCLES  = 150000000
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              key_go,
    input  logic              key_pause,
    input  logic              key_off,
    input  logic              cda_done,
    input  logic              rcm,
    output logic              off,
    output logic              cda,
    output logic              pos,
    output logic              cho_c,
    output logic              ans,
    output logic              pause,
    output logic              load,
    output logic [MOVE_W-1:0] moves_left,
    output logic [3:0]        state_dbg
);

    localparam logic [MOVE_W-1:0] MOVES_FULL = MOVE_W'(MAX_MOVES);
    localparam logic [MOVE_W-1:0] MOVES_ONE  = MOVE_W'(1);

    state_t            state_q, state_d;
    logic [MOVE_W-1:0] moves_left_q, moves_left_d;
    logic              in_wait, pause_toggle, go_ok;
    logic              idle_en, idle_clr, idle_tc;
    logic              anim_en, anim_clr, anim_tc;

`ifdef LED_CTRL_PAUSE_EN
    localparam logic PAUSE_EN = 1'b1;
    logic pause_q, pause_d;

    always_comb begin
        pause_d = pause_q;
        if (key_off || state_q == S_OFF)
            pause_d = 1'b0;
        else if (pause_toggle)
            pause_d = !pause_q;
    end

    always_ff @(posedge clk) begin
        if (!resetn)
            pause_q <= 1'b0;
        else
            pause_q <= pause_d;
    end
`else
    localparam logic PAUSE_EN = 1'b0;
    logic pause_q;
    assign pause_q = 1'b0;
`endif

    assign in_wait      = (state_q == S_WAIT_POS) || (state_q == S_WAIT_COL);
    // key_off outranks key_pause, which outranks key_go and the timeout
    assign pause_toggle = key_pause & PAUSE_EN & in_wait & !key_off;
    assign go_ok        = key_go && !pause_q;

    // Idle time only accrues while parked in a wait state; any state change restarts it
    assign idle_en  = in_wait && !pause_q && !pause_toggle && !key_off;
    assign idle_clr = !in_wait || (state_d != state_q);
    assign anim_en  = (state_q == S_ANIM);
    assign anim_clr = (state_q != S_ANIM);

    led_ctrl_timer #(.TERM(IDLE_TIMEOUT)) u_idle_timer (
        .clk    (clk),
        .resetn (resetn),
        .en     (idle_en),
        .clr    (idle_clr),
        .ld     (1'b0),
        .ld_val ('0),
        .tc     (idle_tc)
    );

    led_ctrl_timer #(.TERM(ANIM_CYCLES)) u_anim_timer (
        .clk    (clk),
        .resetn (resetn),
        .en     (anim_en),
        .clr    (anim_clr),
        .ld     (1'b0),
        .ld_val ('0),
        .tc     (anim_tc)
    );

    always_comb begin
        state_d      = state_q;
        moves_left_d = moves_left_q;
        if (key_off) begin
            state_d = S_OFF;
        end else begin
            case (state_q)
                S_OFF: begin
                    if (key_go) begin
                        moves_left_d = MOVES_FULL;
                        state_d      = S_CDOWN;
                    end
                end
                S_CDOWN: begin
                    if (cda_done)
                        state_d = S_WAIT_POS;
                end
                S_WAIT_POS, S_WAIT_COL: begin
                    if (pause_toggle)
                        state_d = state_q;
                    else if (go_ok)
                        state_d = (state_q == S_WAIT_POS) ? S_LD_POS : S_LD_COL;
                    else if (idle_tc)
                        state_d = S_OFF;
                end
                S_LD_POS: state_d = S_WAIT_COL;
                S_LD_COL: state_d = S_CHECK;
                S_CHECK: begin
                    if (rcm) begin
                        state_d = S_WAIT_POS;
                    end else begin
                        moves_left_d = moves_left_q - 1'b1;
                        state_d      = (moves_left_q == MOVES_ONE) ? S_ANIM : S_WAIT_POS;
                    end
                end
                S_ANIM: begin
                    if (anim_tc)
                        state_d = S_OFF;
                end
                default: state_d = S_OFF;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= S_OFF;
            moves_left_q <= MOVES_FULL;
        end else begin
            state_q      <= state_d;
            moves_left_q <= moves_left_d;
        end
    end

    a_no_underflow: assert property (@(posedge clk) disable iff (!resetn)
        (state_q == S_CHECK && !rcm && !key_off) |-> (moves_left_q != '0));

    assign off        = (state_q == S_OFF);
    assign cda        = (state_q == S_CDOWN);
    assign pos        = (state_q == S_LD_POS);
    assign cho_c      = (state_q == S_LD_COL);
    assign ans        = (state_q == S_ANIM);
    assign load       = pos | cho_c;
    assign pause      = pause_q;
    assign moves_left = moves_left_q;
    assign state_dbg  = state_code(state_q);

endmodule

// File: tb/tb_led_cube_ctrl.sv
// Scoreboard bench for led_cube_ctrl: a game-level reference model predicts the
// outputs after every edge; a negedge monitor pops and compares.
module tb_led_cube_ctrl;

    localparam int MAXM = 2;
    localparam int MW   = 5;
    localparam int ITO  = 20;
    localparam int ANC  = 8;
`ifdef LED_CTRL_PAUSE_EN
    localparam bit PEN = 1'b1;
`else
    localparam bit PEN = 1'b0;
`endif

    localparam int P_OFF = 0, P_CD = 1, P_WP = 2, P_LDP = 3, P_WC = 4, P_LDC = 5, P_CK = 6, P_AN = 7;

    logic clk = 1'b0;
    logic resetn = 1'b0, key_go = 1'b0, key_pause = 1'b0, key_off = 1'b0, cda_done = 1'b0, rcm = 1'b0;
    logic off, cda, pos, cho_c, ans, pause, load;
    logic [MW-1:0] moves_left;
    logic [3:0] state_dbg;

    led_cube_ctrl #(
        .MAX_MOVES(MAXM), .MOVE_W(MW), .IDLE_TIMEOUT(ITO), .ANIM_CYCLES(ANC)
    ) dut (
        .clk(clk), .resetn(resetn), .key_go(key_go), .key_pause(key_pause), .key_off(key_off),
        .cda_done(cda_done), .rcm(rcm), .off(off), .cda(cda), .pos(pos), .cho_c(cho_c),
        .ans(ans), .pause(pause), .load(load), .moves_left(moves_left), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic off, cda, pos, cho_c, ans, pause, load;
        logic [MW-1:0] ml;
        logic [3:0] st;
    } exp_t;

    exp_t q[$];
    exp_t e_mon, a_mon;
    int checks = 0, failures = 0;

    // Reference model: game phase, placements left, cycles idle / animating, pause flag
    int ph = P_OFF, moves = MAXM, idle = 0, anim = 0;
    bit paused = 1'b0;

    function automatic exp_t expect_now();
        exp_t e;
        e.off   = (ph == P_OFF);
        e.cda   = (ph == P_CD);
        e.pos   = (ph == P_LDP);
        e.cho_c = (ph == P_LDC);
        e.ans   = (ph == P_AN);
        e.pause = paused;
        e.load  = (ph == P_LDP) || (ph == P_LDC);
        e.ml    = MW'(moves);
        e.st    = 4'(ph);
        return e;
    endfunction

    task automatic model_step();
        int nph;
        if (!resetn) begin
            ph = P_OFF; moves = MAXM; idle = 0; anim = 0; paused = 1'b0;
            return;
        end
        nph = ph;
        if (key_off) begin
            nph = P_OFF; paused = 1'b0;
        end else begin
            case (ph)
                P_OFF: if (key_go) begin moves = MAXM; nph = P_CD; end
                P_CD:  if (cda_done) nph = P_WP;
                P_WP, P_WC: begin
                    if (PEN && key_pause) paused = !paused;
                    else if (!paused) begin
                        if (key_go) nph = (ph == P_WP) ? P_LDP : P_LDC;
                        else if (idle + 1 == ITO) nph = P_OFF;
                        else idle++;
                    end
                end
                P_LDP: nph = P_WC;
                P_LDC: nph = P_CK;
                P_CK: begin
                    if (rcm) nph = P_WP;
                    else begin
                        moves--;
                        nph = (moves == 0) ? P_AN : P_WP;
                    end
                end
                P_AN: if (anim + 1 == ANC) nph = P_OFF; else anim++;
                default: nph = P_OFF;
            endcase
        end
        if (nph != ph) begin idle = 0; anim = 0; end
        ph = nph;
    endtask

    task automatic tick(input bit g, input bit kp, input bit ko, input bit d, input bit r,
                        input bit rst = 1'b1);
        key_go = g; key_pause = kp; key_off = ko; cda_done = d; rcm = r; resetn = rst;
        @(posedge clk);
        model_step();
        q.push_back(expect_now());
        #1;
    endtask

    task automatic idle_n(input int n);
        repeat (n) tick(0, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            e_mon = q.pop_front();
            a_mon = {off, cda, pos, cho_c, ans, pause, load, moves_left, state_dbg};
            checks++;
            if (a_mon !== e_mon) begin
                failures++;
                $display("FAIL outputs t=%0t got {off cda pos cho_c ans pause load}=%b ml=%0d st=%0d, expected %b ml=%0d st=%0d",
                         $time, a_mon[MW+10:MW+4], a_mon.ml, a_mon.st,
                         e_mon[MW+10:MW+4], e_mon.ml, e_mon.st);
            end
        end
    end

    initial begin
        // reset, start, countdown
        tick(0, 0, 0, 0, 0, 0); tick(0, 0, 0, 0, 0, 0);
        idle_n(2);
        tick(1, 0, 0, 0, 0); idle_n(3); tick(0, 0, 0, 1, 0); idle_n(1);
        // accepted placement
        tick(1, 0, 0, 0, 0); idle_n(2); tick(1, 0, 0, 0, 0); idle_n(4);
        // rejected placement then final placement and animation
        tick(1, 0, 0, 0, 1); tick(0, 0, 0, 0, 1); tick(1, 0, 0, 0, 1);
        tick(0, 0, 0, 0, 1); tick(0, 0, 0, 0, 1); idle_n(1);
        tick(1, 0, 0, 0, 0); idle_n(1); tick(1, 0, 0, 0, 0); idle_n(14);
        // idle timeout in WAIT_COL, then abort in CDOWN
        tick(1, 0, 0, 0, 0); tick(0, 0, 0, 1, 0); tick(1, 0, 0, 0, 0); idle_n(25);
        tick(1, 0, 0, 0, 0); idle_n(2); tick(0, 0, 1, 0, 0); idle_n(2);
        // key_off beats key_go; key_go during LD_COL is dropped
        tick(1, 0, 0, 0, 0); tick(0, 0, 0, 1, 0); tick(1, 0, 1, 0, 0); idle_n(2);
        tick(1, 0, 0, 0, 0); tick(0, 0, 0, 1, 0); tick(1, 0, 0, 0, 0); idle_n(1);
        tick(1, 0, 0, 0, 0); tick(1, 0, 0, 0, 0); idle_n(4); tick(0, 0, 1, 0, 0);
        // pause holds state and freezes the idle timer
        tick(1, 0, 0, 0, 0); tick(0, 0, 0, 1, 0); tick(0, 1, 0, 0, 0); tick(1, 0, 0, 0, 0);
        idle_n(40); tick(0, 1, 0, 0, 0); idle_n(3); tick(0, 1, 0, 0, 0); tick(0, 0, 1, 0, 0);
        tick(0, 0, 0, 0, 0, 0);
        // random traffic
        for (int i = 0; i < 1500; i++)
            tick($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 59) == 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 199) != 0);
        key_go = 0; key_pause = 0; key_off = 0; cda_done = 0; rcm = 0; resetn = 1;
        @(negedge clk); @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
